gba_cheat_engine: RTL and testbench

- Sits on the ROM read path between the SDRAM channel-1 read port and the GBA core's sdram_read_* interface.
- Accepts cheat codes clocked in on the 129-bit code bus from the cheat-code loader and holds up to MAX_CODES entries.
- On every ROM read, it substitutes replacement bytes into the returned dwords wherever an active code's address falls inside them. Compare-gated codes substitute only when the original data matches.

---
 rtl/gba_cheat_pkg.sv | 53 +++++
 rtl/gba_cheat_apply.sv | 47 ++++
 rtl/gba_cheat_engine.sv | 151 +++++++++++++++
 tb/tb_gba_cheat_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_cheat_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gba_cheat_pkg
// Brief    : Shared types, field positions and lane helpers for the cheat engine.
// Revision : 1.0
// ============================================================================
package gba_cheat_pkg;

    typedef struct packed {
        logic [31:0] flags;
        logic [31:0] addr;
        logic [31:0] compare;
        logic [31:0] replace;
    } cheat_entry_t;

    localparam int FLAG_CMP_BIT  = 0;
    localparam int FLAG_SIZE_LSB = 1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int CODE_STROBE_BIT = 128;
    localparam int CODE_FLAGS_LSB  = 96;
    localparam int CODE_ADDR_LSB   = 64;
    localparam int CODE_CMP_LSB    = 32;
    localparam int CODE_REPL_LSB   = 0;

    // Byte lanes touched by a code; size 3 touches nothing so it can never patch.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << lane;
            SIZE_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicate the low bytes of a value into every lane position of its size.
    function automatic logic [31:0] spread(input logic [1:0] size, input logic [31:0] value);
        case (size)
            SIZE_BYTE: spread = {4{value[7:0]}};
            SIZE_HALF: spread = {2{value[15:0]}};
            default:   spread = value;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
        byte_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gba_cheat_apply.sv
`default_nettype none
// ============================================================================
// Module   : gba_cheat_apply
// Brief    : Combinational byte substitution of matching codes into one dword.
// Revision : 1.0
// ============================================================================
module gba_cheat_apply
    import gba_cheat_pkg::*;
#(
    parameter int MAX_CODES = 32
) (
    input  logic                          [31:0] dword_in,
    input  logic                 [MAX_CODES-1:0] match,
    input  cheat_entry_t         [MAX_CODES-1:0] entries,
    output logic                          [31:0] dword_out
);

    logic [31:0]          w_bmask [MAX_CODES];
    logic [31:0]          w_value [MAX_CODES];
    logic [MAX_CODES-1:0] w_hit;

    for (genvar gi = 0; gi < MAX_CODES; gi++) begin : g_entry
        logic [1:0] w_size;
        logic       w_cmp_ok;
        logic       w_unused_bits;

        assign w_size        = entries[gi].flags[FLAG_SIZE_LSB +: 2];
        assign w_bmask[gi]   = byte_mask(lane_mask(w_size, entries[gi].addr[1:0]));
        assign w_value[gi]   = spread(w_size, entries[gi].replace);
        // Compare always looks at the unpatched dword, never at earlier substitutions.
        assign w_cmp_ok      = ((dword_in ^ spread(w_size, entries[gi].compare)) & w_bmask[gi]) == 32'd0;
        assign w_hit[gi]     = match[gi] & (~entries[gi].flags[FLAG_CMP_BIT] | w_cmp_ok);
        assign w_unused_bits = ^{entries[gi].flags[31:3], entries[gi].addr[31:2]};
    end

    // Ascending walk so the highest-index code owns any overlapping lane.
    always_comb begin
        dword_out = dword_in;
        for (int i = 0; i < MAX_CODES; i++) begin
            if (w_hit[i]) begin
                dword_out = (dword_out & ~w_bmask[i]) | (w_value[i] & w_bmask[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gba_cheat_engine.sv
`default_nettype none
// ============================================================================
// Module   : gba_cheat_engine
// Brief    : Cheat code table and ROM read-path patcher between SDRAM and core.
// Revision : 1.0
// ============================================================================
module gba_cheat_engine
    import gba_cheat_pkg::*;
#(
    parameter int MAX_CODES   = 32,
    parameter int ROM_BASE_DW = 196608
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         codes_clear,
    input  logic [128:0]                 code_in,
    output logic [$clog2(MAX_CODES):0]   code_count,
    output logic                         table_full,
    input  logic                         rd_req,
    input  logic [23:0]                  rd_addr,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_data1,
    input  logic [31:0]                  mem_data2,
    output logic                         out_ack,
    output logic [31:0]                  out_data1,
    output logic [31:0]                  out_data2
);

    localparam int                 c_IDX_W = $clog2(MAX_CODES);
    localparam int                 c_CNT_W = c_IDX_W + 1;
    localparam logic [23:0]        c_BASE  = 24'(ROM_BASE_DW);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(MAX_CODES);

    cheat_entry_t [MAX_CODES-1:0] r_table;
    logic [c_CNT_W-1:0]           r_count;
    logic [23:0]                  r_off;
    logic                         r_req_d;
    logic [MAX_CODES-1:0]         r_m1;
    logic [MAX_CODES-1:0]         r_m2;
    logic                         r_pending;
    logic                         r_ack;
    logic [31:0]                  r_data1;
    logic [31:0]                  r_data2;

    cheat_entry_t         w_entry;
    logic                 w_full;
    logic                 w_load;
    logic [22:0]          w_dw1;
    logic [22:0]          w_dw2;
    logic [MAX_CODES-1:0] w_m1;
    logic [MAX_CODES-1:0] w_m2;
    logic [MAX_CODES-1:0] w_sel1;
    logic [MAX_CODES-1:0] w_sel2;
    logic [31:0]          w_patched1;
    logic [31:0]          w_patched2;

    assign w_entry.flags   = code_in[CODE_FLAGS_LSB +: 32];
    assign w_entry.addr    = code_in[CODE_ADDR_LSB  +: 32];
    assign w_entry.compare = code_in[CODE_CMP_LSB   +: 32];
    assign w_entry.replace = code_in[CODE_REPL_LSB  +: 32];

    assign w_full = (r_count == c_FULL);
    assign w_load = code_in[CODE_STROBE_BIT] & ~w_full & ~codes_clear;

    // Entry storage needs no reset: slots at or above code_count never match.
    always_ff @(posedge clk_sys) begin
        if (w_load) begin
            r_table[r_count[c_IDX_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (codes_clear) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign w_dw1 = r_off[22:0];
    assign w_dw2 = r_off[22:0] + 23'd1;

    for (genvar gi = 0; gi < MAX_CODES; gi++) begin : g_match
        logic w_valid;
        // off[23] set means the read fell below the ROM base or past 32MB.
        assign w_valid  = (c_CNT_W'(gi) < r_count) & ~r_off[23];
        assign w_m1[gi] = w_valid & (r_table[gi].addr[24:2] == w_dw1);
        assign w_m2[gi] = w_valid & (r_table[gi].addr[24:2] == w_dw2);
    end

    assign w_sel1 = enable ? r_m1 : '0;
    assign w_sel2 = enable ? r_m2 : '0;

    gba_cheat_apply #(
        .MAX_CODES (MAX_CODES)
    ) u_apply1 (
        .dword_in  (mem_data1),
        .match     (w_sel1),
        .entries   (r_table),
        .dword_out (w_patched1)
    );

    gba_cheat_apply #(
        .MAX_CODES (MAX_CODES)
    ) u_apply2 (
        .dword_in  (mem_data2),
        .match     (w_sel2),
        .entries   (r_table),
        .dword_out (w_patched2)
    );

    // Vectors freeze one cycle after the request, so later loads cannot disturb them.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_off     <= '0;
            r_req_d   <= 1'b0;
            r_m1      <= '0;
            r_m2      <= '0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_data1   <= '0;
            r_data2   <= '0;
        end else begin
            r_req_d   <= rd_req;
            r_pending <= rd_req | (r_pending & ~mem_ack);
            r_ack     <= mem_ack & r_pending;
            if (rd_req) begin
                r_off <= rd_addr - c_BASE;
            end
            if (r_req_d) begin
                r_m1 <= w_m1;
                r_m2 <= w_m2;
            end
            if (mem_ack & r_pending) begin
                r_data1 <= w_patched1;
                r_data2 <= w_patched2;
            end
        end
    end

    assign code_count = r_count;
    assign table_full = w_full;
    assign out_ack    = r_ack;
    assign out_data1  = r_data1;
    assign out_data2  = r_data2;

endmodule
`default_nettype wire

// File: tb/tb_gba_cheat_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gba_cheat_engine
// Brief    : Directed bench with a byte-address reference model of the patcher.
// Revision : 1.0
// ============================================================================
module tb_gba_cheat_engine;

    localparam int MAX_CODES   = 32;
    localparam int ROM_BASE_DW = 196608;
    localparam int CW          = $clog2(MAX_CODES) + 1;

    logic           clk_sys = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b1;
    logic           codes_clear = 1'b0;
    logic [128:0]   code_in = '0;
    logic [CW-1:0]  code_count;
    logic           table_full;
    logic           rd_req = 1'b0;
    logic [23:0]    rd_addr = '0;
    logic           mem_ack = 1'b0;
    logic [31:0]    mem_data1 = '0;
    logic [31:0]    mem_data2 = '0;
    logic           out_ack;
    logic [31:0]    out_data1;
    logic [31:0]    out_data2;

    always #5 clk_sys = ~clk_sys;

    gba_cheat_engine #(
        .MAX_CODES   (MAX_CODES),
        .ROM_BASE_DW (ROM_BASE_DW)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .enable      (enable),
        .codes_clear (codes_clear),
        .code_in     (code_in),
        .code_count  (code_count),
        .table_full  (table_full),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .mem_ack     (mem_ack),
        .mem_data1   (mem_data1),
        .mem_data2   (mem_data2),
        .out_ack     (out_ack),
        .out_data1   (out_data1),
        .out_data2   (out_data2)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_flags [MAX_CODES];
    logic [31:0] m_addr  [MAX_CODES];
    logic [31:0] m_cmp   [MAX_CODES];
    logic [31:0] m_rep   [MAX_CODES];
    int          m_count   = 0;
    int          m_snap    = 0;
    logic [23:0] m_off     = '0;
    bit          m_pending = 1'b0;
    logic        exp_ack   = 1'b0;
    logic [31:0] exp_d1    = '0;
    logic [31:0] exp_d2    = '0;
    bit          chk_on    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-address view: each code covers an aligned run of 1/2/4 ROM bytes.
    function automatic logic [31:0] model_dword(input logic [31:0] raw, input logic [23:0] off,
                                                input bit second, input int cnt, input bit en);
        logic [31:0] res;
        logic [22:0] dw;
        logic [24:0] start;
        int          nbytes;
        int          lane0;
        bit          ok;
        res = raw;
        if (!en || off[23]) return raw;
        dw = second ? off[22:0] + 23'd1 : off[22:0];
        for (int i = 0; i < cnt; i++) begin
            if (m_flags[i][2:1] == 2'd3) continue;
            nbytes = 1 << m_flags[i][2:1];
            start  = m_addr[i][24:0] & ~25'(nbytes - 1);
            if (start[24:2] != dw) continue;
            lane0 = int'(start[1:0]);
            ok = 1'b1;
            if (m_flags[i][0]) begin
                for (int k = 0; k < nbytes; k++)
                    if (raw[8*(lane0+k) +: 8] != m_cmp[i][8*k +: 8]) ok = 1'b0;
            end
            if (ok) begin
                for (int k = 0; k < nbytes; k++)
                    res[8*(lane0+k) +: 8] = m_rep[i][8*k +: 8];
            end
        end
        return res;
    endfunction

    always @(negedge clk_sys) begin
        if (chk_on) begin
            chk("out_ack",    {31'd0, out_ack},    {31'd0, exp_ack});
            chk("out_data1",  out_data1,           exp_d1);
            chk("out_data2",  out_data2,           exp_d2);
            chk("code_count", 32'(code_count),     32'(m_count));
            chk("table_full", {31'd0, table_full}, {31'd0, (m_count == MAX_CODES)});
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic load(input logic [31:0] f, input logic [31:0] a, input logic [31:0] c, input logic [31:0] r);
        code_in = {1'b1, f, a, c, r};
        tick();
        if (m_count < MAX_CODES) begin
            m_flags[m_count] = f;
            m_addr[m_count]  = a;
            m_cmp[m_count]   = c;
            m_rep[m_count]   = r;
            m_count++;
        end
        code_in[128] = 1'b0;
    endtask

    task automatic clear_tbl();
        codes_clear = 1'b1;
        tick();
        m_count = 0;
        codes_clear = 1'b0;
    endtask

    task automatic rd_start(input logic [23:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req    = 1'b0;
        m_off     = a - 24'(ROM_BASE_DW);
        m_pending = 1'b1;
        m_snap    = m_count;
    endtask

    task automatic rd_ack(input logic [31:0] d1, input logic [31:0] d2);
        mem_data1 = d1;
        mem_data2 = d2;
        mem_ack   = 1'b1;
        tick();
        if (m_pending) begin
            exp_ack   = 1'b1;
            exp_d1    = model_dword(d1, m_off, 1'b0, m_snap, enable);
            exp_d2    = model_dword(d2, m_off, 1'b1, m_snap, enable);
            m_pending = 1'b0;
        end
        mem_ack = 1'b0;
        tick();
        exp_ack = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input logic [31:0] d1, input logic [31:0] d2);
        rd_start(a);
        tick();
        rd_ack(d1, d2);
    endtask

    localparam logic [23:0] A40 = 24'(ROM_BASE_DW + 'h40);

    initial begin
        #1 reset = 1'b1;
        chk_on = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_count", 32'(code_count), 32'd0);
        chk("rst_full",  {31'd0, table_full}, 32'd0);
        chk("rst_data1", out_data1, 32'd0);

        // Word code
        load(32'h4, 32'h100, 32'h0, 32'hDEADBEEF);
        do_read(A40, 32'h11223344, 32'h55667788);
        chk("word_d1", out_data1, 32'hDEADBEEF);
        chk("word_d2", out_data2, 32'h55667788);

        // Compare-gated byte code
        clear_tbl();
        load(32'h1, 32'h103, 32'h11, 32'hAB);
        do_read(A40, 32'h11223344, 32'h0);
        chk("byte_cmp_hit", out_data1, 32'hAB223344);
        do_read(A40, 32'h22223344, 32'h0);
        chk("byte_cmp_miss", out_data1, 32'h22223344);

        // Halfword code in the second dword
        clear_tbl();
        load(32'h2, 32'h106, 32'h0, 32'hBEEF);
        do_read(A40, 32'h11223344, 32'h0);
        chk("half_d2", out_data2, 32'hBEEF0000);
        chk("half_d1", out_data1, 32'h11223344);

        // Overlap: highest index wins
        clear_tbl();
        load(32'h4, 32'h100, 32'h0, 32'h1);
        load(32'h4, 32'h100, 32'h0, 32'h2);
        do_read(A40, 32'h11223344, 32'h0);
        chk("overlap", out_data1, 32'h2);

        enable = 1'b0;
        do_read(A40, 32'h11223344, 32'h0);
        chk("disabled", out_data1, 32'h11223344);
        enable = 1'b1;

        // Top of ROM window and the region below base
        clear_tbl();
        load(32'h4, 32'h01FFFFFC, 32'h0, 32'h77777777);
        load(32'h4, 32'h0, 32'h0, 32'h66666666);
        do_read(24'(ROM_BASE_DW + 'h7FFFFF), 32'h11111111, 32'h22222222);
        chk("top_d1", out_data1, 32'h77777777);
        chk("wrap_d2", out_data2, 32'h66666666);
        do_read(24'(ROM_BASE_DW - 1), 32'h11111111, 32'h22222222);
        chk("below_d1", out_data1, 32'h11111111);
        chk("below_d2", out_data2, 32'h22222222);

        clear_tbl();
        load(32'h6, 32'h100, 32'h0, 32'h12345678);
        do_read(A40, 32'h11223344, 32'h0);
        chk("size3", out_data1, 32'h11223344);

        // Load while a read is outstanding
        clear_tbl();
        rd_start(A40);
        load(32'h4, 32'h100, 32'h0, 32'hCAFEF00D);
        rd_ack(32'h11223344, 32'h0);
        chk("load_mid_read", out_data1, 32'h11223344);
        do_read(A40, 32'h11223344, 32'h0);
        chk("load_after", out_data1, 32'hCAFEF00D);

        // Last request wins
        rd_start(24'(ROM_BASE_DW + 'h80));
        rd_start(A40);
        tick();
        rd_ack(32'h11223344, 32'h0);
        chk("last_req", out_data1, 32'hCAFEF00D);

        // Fill, overflow, clear priority
        clear_tbl();
        for (int i = 0; i < MAX_CODES + 3; i++)
            load(32'h4, 32'h1000 + 32'(4 * i), 32'h0, 32'(i));
        chk("fill_count", 32'(code_count), 32'(MAX_CODES));
        chk("fill_full",  {31'd0, table_full}, 32'd1);
        clear_tbl();
        chk("clear_count", 32'(code_count), 32'd0);
        code_in = {1'b1, 32'h4, 32'h100, 32'h0, 32'h5};
        codes_clear = 1'b1;
        tick();
        m_count = 0;
        code_in[128] = 1'b0;
        codes_clear = 1'b0;
        chk("clear_prio", 32'(code_count), 32'd0);
        do_read(A40, 32'h11223344, 32'h0);
        chk("clear_pass", out_data1, 32'h11223344);

        // Asynchronous reset between request and ack
        load(32'h4, 32'h100, 32'h0, 32'hDEADBEEF);
        rd_start(A40);
        #2 reset = 1'b1;
        m_count = 0; m_pending = 1'b0; exp_ack = 1'b0; exp_d1 = '0; exp_d2 = '0;
        tick();
        reset = 1'b0;
        rd_ack(32'h11223344, 32'h0);
        chk("rstmid_ack", {31'd0, out_ack}, 32'd0);
        chk("rstmid_count", 32'(code_count), 32'd0);
        chk("rstmid_data", out_data1, 32'd0);
        do_read(A40, 32'h11223344, 32'h0);
        chk("rstmid_pass", out_data1, 32'h11223344);

        tick();
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
